// File: rtl/snn_noc_pkg.sv
// Shared constants, types and helpers for the SNN NoC output-side collector.
package snn_noc_pkg;

  localparam int unsigned DEPTH_R        = 28;
  localparam int unsigned WIDTH_addr     = 12;
  localparam int unsigned WIDTH_out_data = 13;
  localparam int unsigned NUM_TS         = 2;

  // Derived map geometry: 784 entries per timestep.
  localparam int unsigned MAP_SIZE = DEPTH_R * DEPTH_R;
  // Bank-internal address width (indexes 0..MAP_SIZE-1).
  localparam int unsigned BANK_AW  = $clog2(MAP_SIZE);
  // Fill counter must be able to hold MAP_SIZE itself.
  localparam int unsigned CNT_W    = $clog2(MAP_SIZE + 1);

  typedef logic [1:0] ts_t;
  typedef logic [1:0] layer_t;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StHdr,
    StStream,
    StNext,
    StWait,
    StDone,
    StFin
  } col_state_e;

  // Timesteps are numbered 1..NUM_TS; zero and anything above are invalid.
  function automatic logic ts_in_range(input ts_t ts);
    return (ts != '0) && (32'(ts) <= NUM_TS);
  endfunction

  // Address of the last map entry, sized for the bank address bus.
  function automatic logic [BANK_AW-1:0] last_idx();
    return BANK_AW'(MAP_SIZE - 1);
  endfunction

endpackage

// File: rtl/spike_bank.sv
// One timestep bank: data array, written bitmap, fill counter, write port with
// duplicate detection and a combinational read port.
module spike_bank
  import snn_noc_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_en_i,
  input  logic [BANK_AW-1:0]        wr_addr_i,
  input  logic [WIDTH_out_data-1:0] wr_data_i,
  output logic                      dup_o,
  input  logic [BANK_AW-1:0]        rd_addr_i,
  output logic [WIDTH_out_data-1:0] rd_data_o,
  output logic                      full_o
);

  logic [WIDTH_out_data-1:0] mem_q [MAP_SIZE];
  logic [MAP_SIZE-1:0]       bitmap_q, bitmap_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic                      wr_ok;

  // A write to an already-populated entry is a duplicate; the first value wins.
  assign dup_o  = bitmap_q[wr_addr_i];
  assign wr_ok  = wr_en_i && !dup_o;
  assign full_o = (cnt_q == CNT_W'(MAP_SIZE));

  // Reads come straight from the stored array so a stream beat needs no latency.
  assign rd_data_o = mem_q[rd_addr_i];

  // Next-state of bitmap and fill counter for an accepted, non-duplicate write.
  always_comb begin
    bitmap_d = bitmap_q;
    cnt_d    = cnt_q;
    if (wr_ok) begin
      bitmap_d[wr_addr_i] = 1'b1;
      cnt_d               = cnt_q + CNT_W'(1);
    end
  end

  // Bitmap and counter are the only reset state; data is qualified by the bitmap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bitmap_q <= '0;
      cnt_q    <= '0;
    end else begin
      bitmap_q <= bitmap_d;
      cnt_q    <= cnt_d;
    end
  end

  // Data array write port, no reset needed.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

endmodule

// File: rtl/snn_spike_collector.sv
// Output-side collector: accepts spike words for any timestep in any order,
// stores them per timestep, and streams each complete map in address order
// framed by a start token, per-timestep headers and a final done token.
module snn_spike_collector
  import snn_noc_pkg::*;
#(
  parameter int unsigned LAYER_ID = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  // Input spike words
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  input  ts_t                       in_ts_i,
  input  logic [WIDTH_addr-1:0]     in_addr_i,
  input  logic [WIDTH_out_data-1:0] in_data_i,
  // Start token
  output logic                      start_valid_o,
  input  logic                      start_ready_i,
  // Timestep header
  output logic                      hdr_valid_o,
  input  logic                      hdr_ready_i,
  output ts_t                       hdr_ts_o,
  output layer_t                    hdr_layer_o,
  // Result beats
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [WIDTH_addr-1:0]     out_addr_o,
  output logic [WIDTH_out_data-1:0] out_data_o,
  // Done token
  output logic                      done_valid_o,
  input  logic                      done_ready_i,
  // Sticky error flags
  output logic                      dup_err_o,
  output logic                      addr_err_o,
  output logic                      ts_err_o
);

  col_state_e state_q, state_d;
  ts_t        k_q, k_d;
  logic [BANK_AW-1:0] idx_q, idx_d;

  logic in_acc, ts_ok, addr_ok, dup_hit;
  logic [BANK_AW-1:0] bank_addr;
  logic [NUM_TS-1:0]  wr_en, dup_vec, full_vec;
  logic [WIDTH_out_data-1:0] rd_data [NUM_TS];
  logic [WIDTH_out_data-1:0] cur_rd;
  logic cur_full;

  logic dup_err_q, dup_err_d;
  logic addr_err_q, addr_err_d;
  logic ts_err_q, ts_err_d;

  // ---------------------------------------------------------------------------
  // Input decode and bank array
  // ---------------------------------------------------------------------------
  assign in_acc    = in_valid_i && in_ready_o;
  assign ts_ok     = ts_in_range(in_ts_i);
  assign addr_ok   = (in_addr_i < WIDTH_addr'(MAP_SIZE));
  assign bank_addr = in_addr_i[BANK_AW-1:0];

  for (genvar j = 0; j < NUM_TS; j++) begin : g_bank
    assign wr_en[j] = in_acc && ts_ok && addr_ok && (in_ts_i == ts_t'(j + 1));

    spike_bank u_bank (
      .clk       (clk),
      .rst       (rst),
      .wr_en_i   (wr_en[j]),
      .wr_addr_i (bank_addr),
      .wr_data_i (in_data_i),
      .dup_o     (dup_vec[j]),
      .rd_addr_i (idx_q),
      .rd_data_o (rd_data[j]),
      .full_o    (full_vec[j])
    );
  end

  // Only the addressed bank's bitmap matters for duplicate detection.
  assign dup_hit = |(wr_en & dup_vec);

  // Pick the read data and fill status of the bank for the current timestep k.
  always_comb begin
    cur_full = 1'b0;
    cur_rd   = '0;
    for (int j = 0; j < NUM_TS; j++) begin
      if (k_q == ts_t'(j + 1)) begin
        cur_full = full_vec[j];
        cur_rd   = rd_data[j];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Sticky error flags: one cause per dropped word, checked in priority order
  // ---------------------------------------------------------------------------
  // Next-state of the error flags.
  always_comb begin
    dup_err_d  = dup_err_q;
    addr_err_d = addr_err_q;
    ts_err_d   = ts_err_q;
    if (in_acc) begin
      if (!ts_ok) begin
        ts_err_d = 1'b1;
      end else if (!addr_ok) begin
        addr_err_d = 1'b1;
      end else if (dup_hit) begin
        dup_err_d = 1'b1;
      end
    end
  end

  // Error flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dup_err_q  <= 1'b0;
      addr_err_q <= 1'b0;
      ts_err_q   <= 1'b0;
    end else begin
      dup_err_q  <= dup_err_d;
      addr_err_q <= addr_err_d;
      ts_err_q   <= ts_err_d;
    end
  end

  assign dup_err_o  = dup_err_q;
  assign addr_err_o = addr_err_q;
  assign ts_err_o   = ts_err_q;

  // ---------------------------------------------------------------------------
  // Streaming FSM
  // ---------------------------------------------------------------------------
  // State register together with the timestep and beat index it sequences.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      k_q     <= ts_t'(1);
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    idx_d   = idx_q;
    case (state_q)
      StIdle: begin
        // Nothing is emitted until timestep 1 is complete.
        if (full_vec[0]) begin
          state_d = StStart;
        end
      end
      StStart: begin
        if (start_ready_i) begin
          state_d = StHdr;
          k_d     = ts_t'(1);
        end
      end
      StHdr: begin
        if (hdr_ready_i) begin
          state_d = StStream;
          idx_d   = '0;
        end
      end
      StStream: begin
        if (out_ready_i) begin
          if (idx_q == last_idx()) begin
            state_d = StNext;
          end else begin
            idx_d = idx_q + BANK_AW'(1);
          end
        end
      end
      StNext: begin
        if (k_q == ts_t'(NUM_TS)) begin
          state_d = StDone;
        end else begin
          k_d     = k_q + ts_t'(1);
          state_d = StWait;
        end
      end
      StWait: begin
        if (cur_full) begin
          state_d = StHdr;
        end
      end
      StDone: begin
        if (done_ready_i) begin
          state_d = StFin;
        end
      end
      StFin: begin
        state_d = StFin;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Output decode; payloads are zero whenever their valid is low.
  always_comb begin
    in_ready_o    = !rst && (state_q != StFin);
    start_valid_o = 1'b0;
    hdr_valid_o   = 1'b0;
    hdr_ts_o      = '0;
    hdr_layer_o   = '0;
    out_valid_o   = 1'b0;
    out_addr_o    = '0;
    out_data_o    = '0;
    done_valid_o  = 1'b0;
    case (state_q)
      StStart: begin
        start_valid_o = 1'b1;
      end
      StHdr: begin
        hdr_valid_o = 1'b1;
        hdr_ts_o    = k_q;
        hdr_layer_o = layer_t'(LAYER_ID);
      end
      StStream: begin
        out_valid_o = 1'b1;
        out_addr_o  = WIDTH_addr'(idx_q);
        out_data_o  = cur_rd;
      end
      StDone: begin
        done_valid_o = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_snn_spike_collector.sv
// Scoreboard bench for snn_spike_collector: a reference model of the banks
// predicts the full output token sequence, which a monitor checks in order.
module tb_snn_spike_collector;
  import snn_noc_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic in_valid_i, in_ready_o;
  ts_t  in_ts_i;
  logic [WIDTH_addr-1:0]     in_addr_i;
  logic [WIDTH_out_data-1:0] in_data_i;
  logic start_valid_o, start_ready_i = 1'b1;
  logic hdr_valid_o, hdr_ready_i = 1'b1;
  ts_t  hdr_ts_o;
  layer_t hdr_layer_o;
  logic out_valid_o, out_ready_i = 1'b1;
  logic [WIDTH_addr-1:0]     out_addr_o;
  logic [WIDTH_out_data-1:0] out_data_o;
  logic done_valid_o, done_ready_i = 1'b1;
  logic dup_err_o, addr_err_o, ts_err_o;

  always #5 clk = ~clk;

  snn_spike_collector #(.LAYER_ID(1)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid_i    (in_valid_i),
    .in_ready_o    (in_ready_o),
    .in_ts_i       (in_ts_i),
    .in_addr_i     (in_addr_i),
    .in_data_i     (in_data_i),
    .start_valid_o (start_valid_o),
    .start_ready_i (start_ready_i),
    .hdr_valid_o   (hdr_valid_o),
    .hdr_ready_i   (hdr_ready_i),
    .hdr_ts_o      (hdr_ts_o),
    .hdr_layer_o   (hdr_layer_o),
    .out_valid_o   (out_valid_o),
    .out_ready_i   (out_ready_i),
    .out_addr_o    (out_addr_o),
    .out_data_o    (out_data_o),
    .done_valid_o  (done_valid_o),
    .done_ready_i  (done_ready_i),
    .dup_err_o     (dup_err_o),
    .addr_err_o    (addr_err_o),
    .ts_err_o      (ts_err_o)
  );

  typedef struct packed {
    logic [1:0]  ts;
    logic [11:0] addr;
    logic [12:0] data;
  } word_t;

  word_t       wq[$];
  logic [31:0] sb[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          rmode   = 0;
  int unsigned cyc     = 0;
  int          beats_ts1 = 0;
  logic [1:0]  cur_hdr_ts = '0;

  // Reference model state
  logic [12:0] m_data [2][784];
  bit          m_wr   [2][784];
  int          m_cnt  [2];
  bit          e_dup, e_addr, e_ts;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] tok(input logic [3:0] kind, input logic [11:0] a,
                                      input logic [12:0] d);
    return {3'b000, kind, a, d};
  endfunction

  function automatic word_t mk(input logic [1:0] ts, input int a, input int d);
    word_t w;
    w.ts   = ts;
    w.addr = 12'(a);
    w.data = 13'(d);
    return w;
  endfunction

  // Ready pattern: always ready, or ready one cycle in four.
  always @(posedge clk) begin
    #1;
    cyc++;
    if (rmode == 0) begin
      out_ready_i = 1'b1;
      start_ready_i = 1'b1;
      hdr_ready_i = 1'b1;
      done_ready_i = 1'b1;
    end else begin
      out_ready_i   = (cyc % 4 == 0);
      start_ready_i = (cyc % 4 == 1);
      hdr_ready_i   = (cyc % 4 == 2);
      done_ready_i  = (cyc % 4 == 3);
    end
  end

  // Output monitor: checks each handshake against the scoreboard and that a
  // stalled token stays stable until taken.
  logic [31:0] hold_tok;
  bit          hold_pend = 0;
  always @(negedge clk) begin
    logic [31:0] cur;
    logic        rdy;
    int          nv;
    if (rst) begin
      hold_pend = 0;
    end else begin
      nv  = int'(start_valid_o) + int'(hdr_valid_o) + int'(out_valid_o) + int'(done_valid_o);
      cur = '0;
      rdy = 1'b0;
      if (out_valid_o) begin
        cur = tok(4'd3, out_addr_o, out_data_o);
        rdy = out_ready_i;
      end else if (hdr_valid_o) begin
        cur = tok(4'd2, 12'(hdr_ts_o), 13'(hdr_layer_o));
        rdy = hdr_ready_i;
      end else if (start_valid_o) begin
        cur = tok(4'd1, 12'd0, 13'd1);
        rdy = start_ready_i;
      end else if (done_valid_o) begin
        cur = tok(4'd4, 12'd0, 13'd1);
        rdy = done_ready_i;
      end
      if (nv > 1) check_eq("valid_onehot", 32'(nv), 32'd1);
      if (hold_pend) check_eq("hold_stable", cur, hold_tok);
      hold_pend = 0;
      if (cur != '0) begin
        if (rdy) begin
          if (sb.size() == 0) check_eq("unexpected_token", cur, 32'hDEAD_BEEF);
          else check_eq("token", cur, sb.pop_front());
          if (hdr_valid_o) begin
            cur_hdr_ts = hdr_ts_o;
            beats_ts1  = 0;
          end else if (out_valid_o && cur_hdr_ts == 2'd1) begin
            beats_ts1++;
          end
        end else begin
          hold_pend = 1;
          hold_tok  = cur;
        end
      end
    end
  end

  // Run the model over the whole word list and queue the predicted tokens.
  task automatic build_expected();
    int b;
    for (int t = 0; t < 2; t++) begin
      m_cnt[t] = 0;
      for (int a = 0; a < 784; a++) m_wr[t][a] = 0;
    end
    e_dup = 0; e_addr = 0; e_ts = 0;
    foreach (wq[i]) begin
      if (wq[i].ts == 2'd0 || wq[i].ts > 2'd2) e_ts = 1;
      else if (wq[i].addr >= 12'd784) e_addr = 1;
      else begin
        b = int'(wq[i].ts) - 1;
        if (m_wr[b][wq[i].addr]) e_dup = 1;
        else begin
          m_wr[b][wq[i].addr]   = 1;
          m_data[b][wq[i].addr] = wq[i].data;
          m_cnt[b]++;
        end
      end
    end
    sb.delete();
    if (m_cnt[0] == 784) begin
      sb.push_back(tok(4'd1, 12'd0, 13'd1));
      for (int t = 0; t < 2; t++) begin
        if (m_cnt[t] == 784) begin
          sb.push_back(tok(4'd2, 12'(t + 1), 13'd1));
          for (int a = 0; a < 784; a++) sb.push_back(tok(4'd3, 12'(a), m_data[t][a]));
        end
      end
      if (m_cnt[1] == 784) sb.push_back(tok(4'd4, 12'd0, 13'd1));
    end
  endtask

  task automatic play(input int lo, input int hi);
    int n;
    @(posedge clk); #1;
    for (int i = lo; i <= hi; i++) begin
      in_valid_i = 1'b1;
      in_ts_i    = wq[i].ts;
      in_addr_i  = wq[i].addr;
      in_data_i  = wq[i].data;
      n = 0;
      forever begin
        @(negedge clk);
        if (in_ready_o) break;
        n++;
        if (n > 50) begin
          check_eq("in_ready_timeout", 32'(in_ready_o), 32'd1);
          in_valid_i = 1'b0;
          return;
        end
      end
      @(posedge clk); #1;
    end
    in_valid_i = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_eq("drain", 32'(sb.size()), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk); #2;
    rst = 1'b1;
    in_valid_i = 1'b0;
    #1;
    check_eq("rst_ctrl", {24'd0, start_valid_o, hdr_valid_o, out_valid_o, done_valid_o,
                          in_ready_o, dup_err_o, addr_err_o, ts_err_o}, 32'd0);
    check_eq("rst_data", {3'd0, hdr_ts_o, hdr_layer_o, out_addr_o, out_data_o}, 32'd0);
    sb.delete();
    beats_ts1  = 0;
    cur_hdr_ts = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic build_interleaved(input int dsel);
    wq.delete();
    for (int a = 0; a < 784; a++) begin
      if (dsel == 0) begin
        wq.push_back(mk(2'd1, a, a % 2));
        wq.push_back(mk(2'd2, 783 - a, ((783 - a) * 37 + 11) & 13'h1fff));
      end else begin
        wq.push_back(mk(2'd1, a, a ^ 13'h0a5a));
        wq.push_back(mk(2'd2, a, (a * 5 + 3) & 13'h1fff));
      end
    end
  endtask

  task automatic check_fin();
    repeat (3) @(negedge clk);
    check_eq("fin_in_ready", 32'(in_ready_o), 32'd0);
    check_eq("fin_valids", {28'd0, start_valid_o, hdr_valid_o, out_valid_o, done_valid_o},
             32'd0);
    check_eq("err_flags", {29'd0, dup_err_o, addr_err_o, ts_err_o}, {29'd0, e_dup, e_addr, e_ts});
  endtask

  initial begin
    int n;
    rst = 1'b1;
    in_valid_i = 1'b0;
    in_ts_i = '0;
    in_addr_i = '0;
    in_data_i = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_ctrl", {24'd0, start_valid_o, hdr_valid_o, out_valid_o, done_valid_o,
                          in_ready_o, dup_err_o, addr_err_o, ts_err_o}, 32'd0);
    check_eq("rst_data", {3'd0, hdr_ts_o, hdr_layer_o, out_addr_o, out_data_o}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("in_ready_after_rst", 32'(in_ready_o), 32'd1);

    // Interleaved fill: bank 1 ascending, bank 2 descending.
    build_interleaved(0);
    build_expected();
    rmode = 0;
    play(0, wq.size() - 1);
    wait_drain(10000);
    check_fin();

    // Error words, duplicate, late final address, throttled readies.
    do_reset();
    wq.delete();
    wq.push_back(mk(2'd1, 784, 7));
    wq.push_back(mk(2'd3, 3, 9));
    wq.push_back(mk(2'd0, 1, 1));
    wq.push_back(mk(2'd1, 5, 1));
    wq.push_back(mk(2'd1, 5, 0));
    for (int a = 0; a < 783; a++) if (a != 5) wq.push_back(mk(2'd1, a, (a * 3) & 13'h1fff));
    wq.push_back(mk(2'd1, 783, 13'h1abc));
    for (int a = 0; a < 784; a++) wq.push_back(mk(2'd2, a, (a * 11 + 1) & 13'h1fff));
    build_expected();
    rmode = 1;
    play(0, 2);
    repeat (5) @(negedge clk);
    check_eq("err_after_drops", {29'd0, dup_err_o, addr_err_o, ts_err_o}, 32'b011);
    check_eq("no_start_drops", 32'(start_valid_o), 32'd0);
    play(3, 4);
    @(negedge clk);
    check_eq("dup_err", 32'(dup_err_o), 32'd1);
    play(5, 786);
    repeat (5) @(negedge clk);
    check_eq("no_start_783_missing", 32'(start_valid_o), 32'd0);
    play(787, wq.size() - 1);
    wait_drain(20000);
    check_fin();
    rmode = 0;

    // Reset during stream beat 100 of timestep 1, then a full rerun.
    do_reset();
    build_interleaved(1);
    build_expected();
    play(0, wq.size() - 1);
    n = 0;
    while (!(cur_hdr_ts == 2'd1 && beats_ts1 >= 100) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check_eq("reached_beat100", 32'(beats_ts1), 32'd100);
    do_reset();
    build_interleaved(0);
    build_expected();
    play(0, wq.size() - 1);
    wait_drain(10000);
    check_fin();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
